// File: rtl/sigmoid_pipe.sv
// sigmoid_pipe: two-stage pipelined sigmoid lookup with valid/ready handshake.
//   y = 1 / (1 + e^-x); x is signed Q(XW-XF-1).XF and y is unsigned Q0.YW.
//   The ROM holds only the non-negative half of the curve.
//   Negative inputs use the identity sigmoid(-x) = 1 - sigmoid(x).
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_x operand, in_tag sideband
//   out_valid/out_ready   output handshake; out_y result, out_tag sideband
//   sat_cnt               (SIGMOID_STATS_EN only) count of accepted samples at
//                         the table ends (m == 0 or m == max), saturating
// Optional feature macro: SIGMOID_STATS_EN
module sigmoid_pipe #(
   parameter int unsigned XW = 8,
   parameter int unsigned XF = 4,
   parameter int unsigned YW = 16,
   parameter int unsigned TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] in_x,
   input  logic [TW-1:0] in_tag,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [YW-1:0] out_y,
   output logic [TW-1:0] out_tag
`ifdef SIGMOID_STATS_EN
   ,
   output logic [15:0]   sat_cnt
`endif
);

   localparam int unsigned MW = XW - 1;
   localparam int unsigned NE = 1 << MW;
   // Fixed-point precision used only while building the table.
   localparam int unsigned FB = 48;
   localparam int unsigned AW = 128;

   localparam logic [XW-1:0] XMIN = {1'b1, {(XW-1){1'b0}}};
   localparam logic [MW-1:0] MMAX = {MW{1'b1}};

   // Builds T[m] = min(round(2^YW * e^x / (e^x + 1)), 2^YW-1), x = m/2^XF.
   // This uses integer-only arithmetic, so the table is fixed at elaboration.
   // e^(1/2^XF) comes from a Taylor series.
   // Successive powers of that value give e^x for each entry.
   function automatic logic [NE*YW-1:0] gen_rom();
      logic [AW-1:0]    one;
      logic [AW-1:0]    step;
      logic [AW-1:0]    term;
      logic [AW-1:0]    p;
      logic [AW-1:0]    d;
      logic [AW-1:0]    t;
      logic [AW-1:0]    cap;
      logic [NE*YW-1:0] r;
      one  = AW'(1) << FB;
      term = one;
      step = one;
      for (int k = 1; k < 24; k++) begin
         term = term / (AW'(k) << XF);
         step = step + term;
      end
      cap = (AW'(1) << YW) - AW'(1);
      p   = one;
      r   = '0;
      for (int m = 0; m < int'(NE); m++) begin
         d = p + one;
         // Round to nearest: (2*2^YW*p + d) / (2*d).
         t = ((p << (YW + 1)) + d) / (d << 1);
         if (t > cap) t = cap;
         r[m*YW +: YW] = t[YW-1:0];
         p = (p * step) >> FB;
      end
      return r;
   endfunction

   localparam logic [NE*YW-1:0] ROM_BITS = gen_rom();

   logic [YW-1:0] rom [NE];
   for (genvar i = 0; i < int'(NE); i++) begin : g_rom
      assign rom[i] = ROM_BITS[i*YW +: YW];
   end

   // Global stall: every stage moves together whenever the output slot can drain.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   // Magnitude of the input. The most negative input is clamped to the table end.
   logic [XW-1:0] x_neg;
   logic [MW-1:0] m_c;
   always_comb begin
      x_neg = XW'(~in_x + XW'(1));
      m_c   = in_x[MW-1:0];
      if (in_x[XW-1]) begin
         m_c = (in_x == XMIN) ? MMAX : x_neg[MW-1:0];
      end
   end

   // Stage 1: magnitude, sign, tag.
   logic          s1_valid;
   logic [MW-1:0] s1_m;
   logic          s1_neg;
   logic [TW-1:0] s1_tag;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_m     <= '0;
         s1_neg   <= 1'b0;
         s1_tag   <= '0;
      end else if (adv) begin
         s1_valid <= in_valid;
         s1_m     <= m_c;
         s1_neg   <= in_x[XW-1];
         s1_tag   <= in_tag;
      end
   end

   // Table lookup plus symmetry correction: 2^YW - T is the YW-bit two's complement of T.
   logic [YW-1:0] rom_y;
   logic [YW-1:0] y_c;
   always_comb begin
      rom_y = rom[s1_m];
      y_c   = s1_neg ? YW'(~rom_y + YW'(1)) : rom_y;
   end

   // Stage 2: registered result and tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_y     <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= s1_valid;
         out_y     <= y_c;
         out_tag   <= s1_tag;
      end
   end

`ifdef SIGMOID_STATS_EN
   // Counts accepted samples at either end of the table, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (in_valid && adv && (m_c == MMAX || m_c == '0) &&
                   sat_cnt != 16'hFFFF) begin
         sat_cnt <= sat_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sigmoid_pipe.sv
// Directed bench for sigmoid_pipe with default parameters (Q3.4 in, Q0.16 out).
// The expected outputs are hand-computed as round(65536 * sigmoid(x)).
module tb_sigmoid_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_x;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;
   logic [3:0]  out_tag;
`ifdef SIGMOID_STATS_EN
   logic [15:0] sat_cnt;
`endif

   sigmoid_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag)
`ifdef SIGMOID_STATS_EN
      ,
      .sat_cnt   (sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] y;
      logic [3:0]  tag;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_out = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One handshake cycle, entered at posedge+1.
   // Any delivered output is checked against the in-order expectation queue.
   // A stalled output must hold its values across the edge.
   task automatic cyc(input logic iv, input logic [7:0] x, input logic [3:0] tg,
                      input logic [15:0] ey, input logic ordy, output logic acc);
      exp_t        e;
      logic        hold;
      logic [15:0] hy;
      logic [3:0]  ht;
      hold      = 1'b0;
      hy        = '0;
      ht        = '0;
      in_valid  = iv;
      in_x      = x;
      in_tag    = tg;
      out_ready = ordy;
      #1;
      if (out_valid) begin
         if (ordy) begin
            if (q.size() == 0) begin
               chk("unexpected output", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("out_y", 32'(out_y), 32'(e.y));
               chk("out_tag", 32'(out_tag), 32'(e.tag));
               n_out++;
            end
         end else begin
            hold = 1'b1;
            hy   = out_y;
            ht   = out_tag;
         end
      end
      acc = iv && in_ready;
      if (acc) q.push_back('{y: ey, tag: tg});
      tick();
      if (hold) begin
         chk("stall valid", 32'(out_valid), 32'd1);
         chk("stall out_y", 32'(out_y), 32'(hy));
         chk("stall out_tag", 32'(out_tag), 32'(ht));
      end
   endtask

   task automatic drain(input logic rnd);
      logic acc;
      int   n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         cyc(1'b0, 8'h00, 4'h0, 16'h0000, rnd ? 1'(($urandom & 1)) : 1'b1, acc);
         n++;
      end
      chk("drain timeout", 32'(q.size()), 32'd0);
   endtask

   // Two back-to-back samples; results must appear on consecutive cycles.
   task automatic b2b(input logic [7:0] x0, input logic [3:0] t0, input logic [15:0] y0,
                      input logic [7:0] x1, input logic [3:0] t1, input logic [15:0] y1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = x0;
      in_tag    = t0;
      tick();
      in_x      = x1;
      in_tag    = t1;
      tick();
      in_valid  = 1'b0;
      chk("b2b first valid", 32'(out_valid), 32'd1);
      chk("b2b first y", 32'(out_y), 32'(y0));
      chk("b2b first tag", 32'(out_tag), 32'(t0));
      tick();
      chk("b2b second valid", 32'(out_valid), 32'd1);
      chk("b2b second y", 32'(out_y), 32'(y1));
      chk("b2b second tag", 32'(out_tag), 32'(t1));
      tick();
      chk("b2b idle", 32'(out_valid), 32'd0);
   endtask

   logic [7:0]  xs [8];
   logic [15:0] ys [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic acc;
      int   idx;
      int   n;

      xs = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'h80, 8'h10, 8'hF0, 8'h20};
      ys = '{16'h8000, 16'h8400, 16'h7C00, 16'hFFE9, 16'h0017, 16'hBB27, 16'h44D9, 16'hE17C};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_x      = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_y", 32'(out_y), 32'd0);
      chk("reset out_tag", 32'(out_tag), 32'd0);
`ifdef SIGMOID_STATS_EN
      chk("reset sat_cnt", 32'(sat_cnt), 32'd0);
`endif
      rst = 1'b0;
      chk("in_ready after reset", 32'(in_ready), 32'd1);

      // Zero input: 0x8000 exactly two cycles after acceptance, tag preserved.
      in_valid = 1'b1;
      in_x     = 8'h00;
      in_tag   = 4'hA;
      tick();
      in_valid = 1'b0;
      chk("latency cycle1 valid", 32'(out_valid), 32'd0);
      tick();
      chk("latency cycle2 valid", 32'(out_valid), 32'd1);
      chk("zero y", 32'(out_y), 32'h8000);
      chk("zero tag", 32'(out_tag), 32'hA);
      tick();
      chk("zero done", 32'(out_valid), 32'd0);

      b2b(8'h01, 4'h1, 16'h8400, 8'hFF, 4'h2, 16'h7C00);
      b2b(8'h7F, 4'h3, 16'hFFE9, 8'h80, 4'h4, 16'h0017);

      // Eight-sample stream under random backpressure.
      n_out = 0;
      idx   = 0;
      n     = 0;
      while (idx < 8 && n < 200) begin
         cyc(1'b1, xs[idx], 4'(idx), ys[idx], 1'(($urandom & 1)), acc);
         if (acc) idx++;
         n++;
      end
      chk("stream accept timeout", 32'(idx), 32'd8);
      drain(1'b1);
      chk("stream count", 32'(n_out), 32'd8);

      // Reset while two samples are in flight.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_x      = 8'h10;
      in_tag    = 4'h9;
      tick();
      in_x      = 8'h20;
      in_tag    = 4'hB;
      tick();
      in_valid  = 1'b0;
      rst       = 1'b1;
      tick();
      rst       = 1'b0;
      chk("flush out_valid", 32'(out_valid), 32'd0);
      chk("flush out_y", 32'(out_y), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("no stale output", 32'(out_valid), 32'd0);
      end
      q.delete();

`ifdef SIGMOID_STATS_EN
      chk("sat_cnt cleared", 32'(sat_cnt), 32'd0);
      cyc(1'b1, 8'h00, 4'h1, 16'h8000, 1'b1, acc);
      cyc(1'b1, 8'h7F, 4'h2, 16'hFFE9, 1'b1, acc);
      cyc(1'b1, 8'h80, 4'h3, 16'h0017, 1'b1, acc);
      cyc(1'b1, 8'h10, 4'h4, 16'hBB27, 1'b1, acc);
      drain(1'b0);
      chk("sat_cnt", 32'(sat_cnt), 32'd3);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sigmoid_pipe.md
SIGMOID_PIPE -- requirements
Module: sigmoid_pipe

Interface
REQ-001 SHALL have parameter XW, default 8, meaning signed two's-complement input width.
REQ-002 SHALL have parameter XF, default 4, meaning input fractional bits (default Q3.4).
REQ-003 SHALL have parameter YW, default 16, meaning unsigned output width, format Q0.YW.
REQ-004 SHALL have parameter TW, default 4, meaning sideband tag width, passed through unchanged.
REQ-005 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  the in_x/in_tag pair is valid.
REQ-008 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port in_x  input  XW  signed operand.
REQ-010 SHALL have port in_tag  input  TW  sideband tag.
REQ-011 SHALL have port out_valid  output  1  the out_y/out_tag pair is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts output.
REQ-013 SHALL have port out_y  output  YW  sigmoid result.
REQ-014 SHALL have port out_tag  output  TW  tag of the same sample.
REQ-015 SHALL, with SIGMOID_STATS_EN defined, add port sat_cnt  output  16  count of accepted saturated samples.

Function
REQ-016 SHALL store a ROM T of 2^(XW-1) entries indexed by magnitude m, with T[m] = min(round(2^YW / (1 + e^(-m/2^XF))), 2^YW-1); contents are fixed at elaboration.
REQ-017 SHALL compute m = |in_x|, and SHALL clamp m to 2^(XW-1)-1 when in_x is the most negative value.
REQ-018 SHALL produce out_y = T[m] for in_x >= 0 and out_y = 2^YW - T[m] for in_x < 0, with no overflow (T[m] >= 2^(YW-1)).
REQ-019 SHALL be a 2-stage pipeline: stage 1 registers m, the sign and the tag; stage 2 registers the ROM result after symmetry correction, together with the tag.
REQ-020 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-021 SHALL sustain a throughput of one sample per cycle when out_ready is held high.
REQ-022 SHALL use a global stall: adv = !out_valid || out_ready; in_ready = adv; all stages shift only when adv is high.
REQ-023 SHALL accept a sample when in_valid and in_ready are both high; SHALL carry a bubble (valid bit 0) when in_valid is low during adv.
REQ-024 SHALL hold out_y, out_tag and out_valid stable while out_valid is high and out_ready is low.
REQ-025 SHALL allow a sample to be accepted and a sample to be delivered in the same cycle, with no loss and no duplication.
REQ-026 SHALL let in_ready depend combinationally only on out_valid and out_ready, and never on in_valid.
REQ-027 SHALL make out_y and out_tag don't-care when out_valid is low.

Reset
REQ-028 SHALL, when rst is sampled high, clear both stage valid bits, force out_valid to 0 and out_y/out_tag to 0, and clear sat_cnt when present.
REQ-029 SHALL, on reset mid-operation, discard in-flight samples; none SHALL appear after reset.
REQ-030 SHALL hold in_ready at 1 in the first cycle after reset deasserts.

Configuration
REQ-031 SHALL, with macro SIGMOID_STATS_EN defined, increment sat_cnt by 1 for each accepted sample with m >= 2^(XW-1)-1 or m == 0.
REQ-032 SHALL make sat_cnt saturate at 16'hFFFF and not wrap.
REQ-033 SHALL, without SIGMOID_STATS_EN, have no sat_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-034 SHALL cover: defaults, in_x=8'h00 with out_ready=1 -> out_y=16'h8000 exactly 2 cycles later, with the tag preserved.
REQ-035 SHALL cover: in_x=8'h01 then 8'hFF back-to-back -> out_y=16'h8400 then 16'h7C00 on consecutive cycles.
REQ-036 SHALL cover: in_x=8'h7F -> 16'hFFE9, and in_x=8'h80 (clamped) -> 16'h0017.
REQ-037 SHALL cover: a stream of 8 samples with out_ready toggling randomly -> all 8 outputs in order with matching tags, and the output held stable during stall.
REQ-038 SHALL cover: rst pulsed while 2 samples are in flight -> out_valid=0 the next cycle and no stale outputs afterwards.
REQ-039 SHALL cover: with SIGMOID_STATS_EN, inputs 8'h00, 8'h7F, 8'h80, 8'h10 -> sat_cnt=3.
